// File: rtl/ring_decoder.sv
// Receive-side ring-code decoder: one-hot/rotation checker with lock FSM and fault counter.
// Optional RING_DEC_REV_CNT_EN adds a 16-bit revolution counter output (rev_cnt).
module ring_decoder #(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_LEN = 2,
  parameter int unsigned HOLD_OK  = 1,
  localparam int unsigned W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:N-1] ring_in,
  input  logic         ring_vld,
  output logic [W-1:0] idx,
  output logic         idx_vld,
  output logic         locked,
  output logic         onehot_err,
  output logic         seq_err,
`ifdef RING_DEC_REV_CNT_EN
  output logic [15:0]  rev_cnt,
`endif
  output logic [7:0]   err_cnt
);

  localparam int unsigned CW = $clog2(N + 1);
  localparam logic [3:0] LockLen = 4'(LOCK_LEN);

  typedef enum logic [1:0] {StUnlocked, StLocked, StFault} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   idx_q, idx_d;
  logic           idx_vld_q, idx_vld_d;
  logic           onehot_err_q, onehot_err_d;
  logic           seq_err_q, seq_err_d;
  logic [7:0]     err_cnt_q, err_cnt_d;
  logic [3:0]     lock_cnt_q, lock_cnt_d;

  logic [W-1:0]   dec_idx;
  logic [CW-1:0]  ones;
  logic           is_onehot;
  logic [W-1:0]   next_idx;
  logic           step_ok;
  logic [7:0]     err_inc;

`ifdef RING_DEC_REV_CNT_EN
  logic [15:0]    rev_cnt_q, rev_cnt_d;
  logic           wrap;
  assign wrap    = (idx_q == W'(N - 1)) && (dec_idx == '0);
  assign rev_cnt = rev_cnt_q;
`endif

  always_comb begin
    dec_idx = '0;
    ones    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ring_in[i]) begin
        dec_idx = W'(i);
        ones    = ones + CW'(1);
      end
    end
  end

  assign is_onehot = (ones == CW'(1));
  assign next_idx  = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
  assign step_ok   = (dec_idx == next_idx) || ((HOLD_OK != 0) && (dec_idx == idx_q));
  assign err_inc   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    idx_vld_d    = 1'b0;
    onehot_err_d = 1'b0;
    seq_err_d    = 1'b0;
    err_cnt_d    = err_cnt_q;
    lock_cnt_d   = lock_cnt_q;
`ifdef RING_DEC_REV_CNT_EN
    rev_cnt_d    = rev_cnt_q;
`endif
    if (ring_vld) begin
      if (!is_onehot) begin
        onehot_err_d = 1'b1;
        lock_cnt_d   = 4'd0;
        if (state_q == StLocked) begin
          state_d   = StFault;
          err_cnt_d = err_inc;
        end
      end else begin
        idx_vld_d = 1'b1;
        idx_d     = dec_idx;
        case (state_q)
          StLocked: begin
            if (!step_ok) begin
              seq_err_d  = 1'b1;
              state_d    = StFault;
              err_cnt_d  = err_inc;
              lock_cnt_d = 4'd1;
            end
`ifdef RING_DEC_REV_CNT_EN
            else if (wrap) begin
              rev_cnt_d = rev_cnt_q + 16'd1;
            end
`endif
          end
          default: begin
            // An empty count means this sample starts a fresh acquisition attempt.
            if ((lock_cnt_q == 4'd0) || !step_ok) begin
              lock_cnt_d = 4'd1;
            end else begin
              lock_cnt_d = lock_cnt_q + 4'd1;
            end
            if (lock_cnt_d >= LockLen) begin
              state_d = StLocked;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StUnlocked;
      idx_q        <= '0;
      idx_vld_q    <= 1'b0;
      onehot_err_q <= 1'b0;
      seq_err_q    <= 1'b0;
      err_cnt_q    <= 8'd0;
      lock_cnt_q   <= 4'd0;
`ifdef RING_DEC_REV_CNT_EN
      rev_cnt_q    <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      idx_vld_q    <= idx_vld_d;
      onehot_err_q <= onehot_err_d;
      seq_err_q    <= seq_err_d;
      err_cnt_q    <= err_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
`ifdef RING_DEC_REV_CNT_EN
      rev_cnt_q    <= rev_cnt_d;
`endif
    end
  end

  assign idx        = idx_q;
  assign idx_vld    = idx_vld_q;
  assign locked     = (state_q == StLocked);
  assign onehot_err = onehot_err_q;
  assign seq_err    = seq_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ring_decoder.sv
// Self-checking bench for ring_decoder: directed scenarios plus randomized traffic vs. a model.
// A second instance (HOLD_OK=0, LOCK_LEN=1) shares the inputs for the boundary cases.
module tb_ring_decoder;
  localparam int N = 4;
  localparam int LOCK_LEN = 2;
  localparam int HOLD_OK = 1;
  localparam int MUnlocked = 0, MLocked = 1, MFault = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [0:N-1] ring_in = '0;
  logic         ring_vld = 1'b0;
  logic [1:0]   idx, nh_idx;
  logic         idx_vld, locked, onehot_err, seq_err;
  logic         nh_idx_vld, nh_locked, nh_onehot_err, nh_seq_err;
  logic [7:0]   err_cnt, nh_err_cnt;
`ifdef RING_DEC_REV_CNT_EN
  logic [15:0]  rev_cnt, nh_rev_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_state, m_idx, m_lock_cnt, m_err, m_rev;
  bit m_vld, m_oh, m_seq;

  always #5 clk = ~clk;

  ring_decoder #(.N(N), .LOCK_LEN(LOCK_LEN), .HOLD_OK(HOLD_OK)) dut (
    .clk(clk), .rst(rst), .ring_in(ring_in), .ring_vld(ring_vld),
    .idx(idx), .idx_vld(idx_vld), .locked(locked), .onehot_err(onehot_err),
    .seq_err(seq_err),
`ifdef RING_DEC_REV_CNT_EN
    .rev_cnt(rev_cnt),
`endif
    .err_cnt(err_cnt)
  );

  ring_decoder #(.N(N), .LOCK_LEN(1), .HOLD_OK(0)) dut_nh (
    .clk(clk), .rst(rst), .ring_in(ring_in), .ring_vld(ring_vld),
    .idx(nh_idx), .idx_vld(nh_idx_vld), .locked(nh_locked), .onehot_err(nh_onehot_err),
    .seq_err(nh_seq_err),
`ifdef RING_DEC_REV_CNT_EN
    .rev_cnt(nh_rev_cnt),
`endif
    .err_cnt(nh_err_cnt)
  );

  task automatic model_reset();
    m_state = MUnlocked; m_idx = 0; m_lock_cnt = 0; m_err = 0; m_rev = 0;
    m_vld = 0; m_oh = 0; m_seq = 0;
  endtask

  task automatic model_step(input logic vld, input logic [0:N-1] code);
    int ones, pos;
    bit legal;
    m_vld = 0; m_oh = 0; m_seq = 0;
    if (!vld) return;
    ones = 0; pos = 0;
    for (int i = 0; i < N; i++) if (code[i]) begin ones++; pos = i; end
    if (ones != 1) begin
      m_oh = 1;
      m_lock_cnt = 0;
      if (m_state == MLocked) begin
        m_state = MFault;
        if (m_err < 255) m_err++;
      end
      return;
    end
    m_vld = 1;
    legal = ((pos - m_idx + N) % N == 1) || (HOLD_OK != 0 && pos == m_idx);
    if (m_state == MLocked) begin
      if (legal) begin
        if (m_idx == N - 1 && pos == 0) m_rev = (m_rev + 1) % 65536;
      end else begin
        m_seq = 1; m_state = MFault; m_lock_cnt = 1;
        if (m_err < 255) m_err++;
      end
    end else begin
      m_lock_cnt = (m_lock_cnt == 0 || !legal) ? 1 : m_lock_cnt + 1;
      if (m_lock_cnt >= LOCK_LEN) m_state = MLocked;
    end
    m_idx = pos;
  endtask

  task automatic apply(input logic vld, input logic [0:N-1] code);
    @(negedge clk);
    ring_vld = vld;
    ring_in  = code;
    @(posedge clk);
    #1;
    model_step(vld, code);
    ring_vld = 1'b0;
  endtask

  function automatic logic [0:N-1] onehot_of(input int k);
    logic [0:N-1] c;
    c = '0;
    c[k % N] = 1'b1;
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ring_vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({idx, idx_vld, locked, onehot_err, seq_err, err_cnt} !== 14'd0) begin
      errors++; $display("FAIL reset_outputs got %h want 0",
                         {idx, idx_vld, locked, onehot_err, seq_err, err_cnt}); end
    checks++; if ({nh_idx, nh_idx_vld, nh_locked, nh_err_cnt} !== 12'd0) begin
      errors++; $display("FAIL reset_nh_outputs got %h want 0",
                         {nh_idx, nh_idx_vld, nh_locked, nh_err_cnt}); end
  endtask

  task automatic test_lock();
    apply(1'b1, 4'b1000);
    checks++; if (idx !== 2'd0 || idx_vld !== 1'b1 || locked !== 1'b0) begin errors++;
      $display("FAIL lock_first got idx=%0d vld=%b lk=%b want 0 1 0", idx, idx_vld, locked); end
    apply(1'b1, 4'b0100);
    checks++; if (idx !== 2'd1 || locked !== 1'b1 || err_cnt !== 8'd0) begin errors++;
      $display("FAIL lock_second got idx=%0d lk=%b ec=%0d want 1 1 0", idx, locked, err_cnt); end
  endtask

  task automatic test_rotate();
    logic [0:N-1] codes [3];
    codes = '{4'b0010, 4'b0001, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, codes[i]);
      checks++; if (idx !== 2'((i + 2) % N) || locked !== 1'b1 || onehot_err || seq_err) begin
        errors++; $display("FAIL rotate_%0d got idx=%0d lk=%b oh=%b sq=%b want %0d 1 0 0",
                           i, idx, locked, onehot_err, seq_err, (i + 2) % N); end
    end
`ifdef RING_DEC_REV_CNT_EN
    checks++; if (rev_cnt !== 16'd1) begin errors++;
      $display("FAIL rotate_rev got %0d want 1", rev_cnt); end
`endif
  endtask

  task automatic test_onehot_fault();
    apply(1'b1, 4'b0100);
    apply(1'b1, 4'b0110);
    checks++; if (onehot_err !== 1'b1 || seq_err !== 1'b0 || idx !== 2'd1 || idx_vld !== 1'b0)
    begin errors++; $display("FAIL oh_fault got oh=%b sq=%b idx=%0d vld=%b want 1 0 1 0",
                             onehot_err, seq_err, idx, idx_vld); end
    checks++; if (locked !== 1'b0 || err_cnt !== 8'd1) begin errors++;
      $display("FAIL oh_fault_state got lk=%b ec=%0d want 0 1", locked, err_cnt); end
    apply(1'b1, 4'b0010);
    checks++; if (locked !== 1'b0 || idx !== 2'd2 || onehot_err !== 1'b0) begin errors++;
      $display("FAIL oh_relock1 got lk=%b idx=%0d oh=%b want 0 2 0", locked, idx, onehot_err); end
    apply(1'b1, 4'b0001);
    checks++; if (locked !== 1'b1 || idx !== 2'd3 || err_cnt !== 8'd1) begin errors++;
      $display("FAIL oh_relock2 got lk=%b idx=%0d ec=%0d want 1 3 1", locked, idx, err_cnt); end
  endtask

  task automatic test_seq_fault();
    apply(1'b1, 4'b1000);
    checks++; if (idx !== 2'd0 || locked !== 1'b1) begin errors++;
      $display("FAIL seq_pre got idx=%0d lk=%b want 0 1", idx, locked); end
    apply(1'b1, 4'b0010);
    checks++; if (seq_err !== 1'b1 || onehot_err !== 1'b0 || idx !== 2'd2 || idx_vld !== 1'b1)
    begin errors++; $display("FAIL seq_fault got sq=%b oh=%b idx=%0d vld=%b want 1 0 2 1",
                             seq_err, onehot_err, idx, idx_vld); end
    checks++; if (err_cnt !== 8'd2 || locked !== 1'b0) begin errors++;
      $display("FAIL seq_fault_state got ec=%0d lk=%b want 2 0", err_cnt, locked); end
  endtask

  task automatic test_hold_lock1();
    do_reset();
    apply(1'b1, 4'b1000);
    checks++; if (nh_locked !== 1'b1 || nh_idx !== 2'd0 || locked !== 1'b0) begin errors++;
      $display("FAIL lock1_first got nh_lk=%b nh_idx=%0d lk=%b want 1 0 0",
               nh_locked, nh_idx, locked); end
    apply(1'b1, 4'b0100);
    apply(1'b1, 4'b0100);
    checks++; if (nh_seq_err !== 1'b1 || nh_locked !== 1'b0 || nh_err_cnt !== 8'd1) begin
      errors++; $display("FAIL nohold_repeat got sq=%b lk=%b ec=%0d want 1 0 1",
                         nh_seq_err, nh_locked, nh_err_cnt); end
    checks++; if (seq_err !== 1'b0 || locked !== 1'b1 || idx !== 2'd1) begin errors++;
      $display("FAIL hold_repeat got sq=%b lk=%b idx=%0d want 0 1 1", seq_err, locked, idx); end
  endtask

  task automatic test_vld_low();
    logic [1:0] held;
    held = idx;
    apply(1'b0, 4'b1111);
    checks++; if (onehot_err || seq_err || idx_vld || idx !== held || locked !== 1'b1) begin
      errors++; $display("FAIL vld_low got oh=%b sq=%b vld=%b idx=%0d lk=%b want 0 0 0 %0d 1",
                         onehot_err, seq_err, idx_vld, idx, locked, held); end
    apply(1'b0, 4'b0000);
    checks++; if (onehot_err || seq_err || idx_vld) begin errors++;
      $display("FAIL vld_low_zero got oh=%b sq=%b vld=%b want 0 0 0",
               onehot_err, seq_err, idx_vld); end
  endtask

  task automatic test_saturate();
    do_reset();
    apply(1'b1, 4'b1000);
    apply(1'b1, 4'b0100);
    for (int i = 0; i < 300; i++) begin
      apply(1'b1, onehot_of(m_idx + 2));
      if (i == 253) begin
        checks++; if (err_cnt !== 8'd254) begin errors++;
          $display("FAIL sat_pre got %0d want 254", err_cnt); end
      end
      apply(1'b1, onehot_of(m_idx + 1));
    end
    checks++; if (err_cnt !== 8'd255 || locked !== 1'b1) begin errors++;
      $display("FAIL sat_final got ec=%0d lk=%b want 255 1", err_cnt, locked); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < N && m_idx != 3; i++) apply(1'b1, onehot_of(m_idx + 1));
    checks++; if (idx !== 2'd3 || locked !== 1'b1) begin errors++;
      $display("FAIL midrst_pre got idx=%0d lk=%b want 3 1", idx, locked); end
    @(negedge clk);
    rst = 1'b1; ring_vld = 1'b1; ring_in = 4'b0100;
    @(posedge clk);
    #1;
    rst = 1'b0; ring_vld = 1'b0;
    model_reset();
    checks++; if ({idx, idx_vld, locked, onehot_err, seq_err, err_cnt} !== 14'd0) begin
      errors++; $display("FAIL midrst_outputs got %h want 0",
                         {idx, idx_vld, locked, onehot_err, seq_err, err_cnt}); end
    apply(1'b1, 4'b0001);
    checks++; if (idx !== 2'd3 || locked !== 1'b0 || idx_vld !== 1'b1) begin errors++;
      $display("FAIL midrst_after got idx=%0d lk=%b vld=%b want 3 0 1", idx, locked, idx_vld); end
  endtask

  task automatic test_random();
    logic [0:N-1] c;
    int r;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       c = onehot_of(m_idx + 1);
      else if (r == 6) c = onehot_of(m_idx);
      else if (r == 7) c = onehot_of($urandom_range(0, N - 1));
      else begin
        c = 4'($urandom);
        if ($countones(c) == 1) c = '0;
      end
      apply(r != 9, c);
      checks++;
      if (idx !== 2'(m_idx) || idx_vld !== m_vld || locked !== (m_state == MLocked) ||
          onehot_err !== m_oh || seq_err !== m_seq || err_cnt !== 8'(m_err)) begin
        errors++;
        $display("FAIL random_%0d got idx=%0d vld=%b lk=%b oh=%b sq=%b ec=%0d want %0d %b %b %b %b %0d",
                 n, idx, idx_vld, locked, onehot_err, seq_err, err_cnt,
                 m_idx, m_vld, m_state == MLocked, m_oh, m_seq, m_err);
      end
`ifdef RING_DEC_REV_CNT_EN
      checks++; if (rev_cnt !== 16'(m_rev)) begin errors++;
        $display("FAIL random_rev_%0d got %0d want %0d", n, rev_cnt, m_rev); end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_rotate();
    test_onehot_fault();
    test_seq_fault();
    test_hold_lock1();
    test_vld_low();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
